// File: rtl/rs_bank_if.sv
// rtl/rs_bank_if.sv - dispatch, CDB, issue and status bundle of the reservation station
interface rs_bank_if #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 5,
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 8
);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  logic              dispatch_valid;
  logic              dispatch_ready;
  logic [DATA_W-1:0] dispatch_opa;
  logic              dispatch_opa_valid;
  logic [TAG_W-1:0]  dispatch_opa_tag;
  logic [DATA_W-1:0] dispatch_opb;
  logic              dispatch_opb_valid;
  logic [TAG_W-1:0]  dispatch_opb_tag;
  logic [TAG_W-1:0]  dispatch_dest_tag;
  logic [CTRL_W-1:0] dispatch_ctrl;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;

  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_opa;
  logic [DATA_W-1:0] issue_opb;
  logic [TAG_W-1:0]  issue_dest_tag;
  logic [CTRL_W-1:0] issue_ctrl;

  logic              flush;
  logic [CNT_W-1:0]  free_count;
  logic              full;

  modport master (
    output dispatch_valid, dispatch_opa, dispatch_opa_valid, dispatch_opa_tag,
           dispatch_opb, dispatch_opb_valid, dispatch_opb_tag, dispatch_dest_tag,
           dispatch_ctrl, cdb_valid, cdb_tag, cdb_value, issue_ready, flush,
    input  dispatch_ready, issue_valid, issue_opa, issue_opb, issue_dest_tag,
           issue_ctrl, free_count, full
  );

  modport slave (
    input  dispatch_valid, dispatch_opa, dispatch_opa_valid, dispatch_opa_tag,
           dispatch_opb, dispatch_opb_valid, dispatch_opb_tag, dispatch_dest_tag,
           dispatch_ctrl, cdb_valid, cdb_tag, cdb_value, issue_ready, flush,
    output dispatch_ready, issue_valid, issue_opa, issue_opb, issue_dest_tag,
           issue_ctrl, free_count, full
  );
endinterface

// File: rtl/rs_bank.sv
// rtl/rs_bank.sv - multi-entry reservation station with CDB wakeup and fixed-priority issue
module rs_bank #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 5,
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 8
) (
  input logic   clock,
  input logic   reset,
  rs_bank_if.slave bus
);
  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [NUM_ENTRIES-1:0] opa_rdy_q, opa_rdy_d;
  logic [NUM_ENTRIES-1:0] opb_rdy_q, opb_rdy_d;
  logic [DATA_W-1:0]      opa_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      opa_d [NUM_ENTRIES];
  logic [DATA_W-1:0]      opb_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      opb_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       opa_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       opa_tag_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       opb_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       opb_tag_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_d [NUM_ENTRIES];
  logic [CTRL_W-1:0]      ctrl_q [NUM_ENTRIES];
  logic [CTRL_W-1:0]      ctrl_d [NUM_ENTRIES];

  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [CNT_W-1:0] free_cnt;
  logic             full_w;
  logic             dispatch_ready_w;
  logic             issue_valid_w;
  logic             dispatch_fire;
  logic             issue_fire;
  logic             opa_bypass;
  logic             opb_bypass;

  // Downward scan so the last hit is the lowest index for both free and ready entries.
  always_comb begin
    alloc_idx = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    free_cnt  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_idx = IDX_W'(i);
      end
      if (busy_q[i] && opa_rdy_q[i] && opb_rdy_q[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
      free_cnt = free_cnt + {{(CNT_W-1){1'b0}}, ~busy_q[i]};
    end
  end

  assign full_w           = (free_cnt == '0);
  assign dispatch_ready_w = !full_w && !bus.flush;
  assign issue_valid_w    = sel_found && !bus.flush;
  assign dispatch_fire    = bus.dispatch_valid && dispatch_ready_w;
  assign issue_fire       = issue_valid_w && bus.issue_ready;

  assign opa_bypass = !bus.dispatch_opa_valid && bus.cdb_valid &&
                      (bus.cdb_tag == bus.dispatch_opa_tag);
  assign opb_bypass = !bus.dispatch_opb_valid && bus.cdb_valid &&
                      (bus.cdb_tag == bus.dispatch_opb_tag);

  assign bus.dispatch_ready = dispatch_ready_w;
  assign bus.full           = full_w;
  assign bus.free_count     = free_cnt;
  assign bus.issue_valid    = issue_valid_w;
  assign bus.issue_opa      = issue_valid_w ? opa_q[sel_idx]  : '0;
  assign bus.issue_opb      = issue_valid_w ? opb_q[sel_idx]  : '0;
  assign bus.issue_dest_tag = issue_valid_w ? dest_q[sel_idx] : '0;
  assign bus.issue_ctrl     = issue_valid_w ? ctrl_q[sel_idx] : '0;

  always_comb begin
    busy_d    = busy_q;
    opa_rdy_d = opa_rdy_q;
    opb_rdy_d = opb_rdy_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opa_tag_d = opa_tag_q;
    opb_tag_d = opb_tag_q;
    dest_d    = dest_q;
    ctrl_d    = ctrl_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (bus.cdb_valid && busy_q[i]) begin
          if (!opa_rdy_q[i] && (opa_tag_q[i] == bus.cdb_tag)) begin
            opa_d[i]     = bus.cdb_value;
            opa_rdy_d[i] = 1'b1;
          end
          if (!opb_rdy_q[i] && (opb_tag_q[i] == bus.cdb_tag)) begin
            opb_d[i]     = bus.cdb_value;
            opb_rdy_d[i] = 1'b1;
          end
        end
      end
      if (issue_fire) begin
        busy_d[sel_idx] = 1'b0;
      end
      // alloc_idx is a free entry, so it can never collide with the issuing one.
      if (dispatch_fire) begin
        busy_d[alloc_idx]    = 1'b1;
        opa_rdy_d[alloc_idx] = bus.dispatch_opa_valid || opa_bypass;
        opb_rdy_d[alloc_idx] = bus.dispatch_opb_valid || opb_bypass;
        opa_d[alloc_idx]     = opa_bypass ? bus.cdb_value : bus.dispatch_opa;
        opb_d[alloc_idx]     = opb_bypass ? bus.cdb_value : bus.dispatch_opb;
        opa_tag_d[alloc_idx] = bus.dispatch_opa_tag;
        opb_tag_d[alloc_idx] = bus.dispatch_opb_tag;
        dest_d[alloc_idx]    = bus.dispatch_dest_tag;
        ctrl_d[alloc_idx]    = bus.dispatch_ctrl;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q    <= '0;
      opa_rdy_q <= '0;
      opb_rdy_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        opa_q[i]     <= '0;
        opb_q[i]     <= '0;
        opa_tag_q[i] <= '0;
        opb_tag_q[i] <= '0;
        dest_q[i]    <= '0;
        ctrl_q[i]    <= '0;
      end
    end else begin
      busy_q    <= busy_d;
      opa_rdy_q <= opa_rdy_d;
      opb_rdy_q <= opb_rdy_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opa_tag_q <= opa_tag_d;
      opb_tag_q <= opb_tag_d;
      dest_q    <= dest_d;
      ctrl_q    <= ctrl_d;
    end
  end
endmodule

// File: tb/tb_rs_bank.sv
// tb/tb_rs_bank.sv - directed scoreboard bench for rs_bank
module tb_rs_bank;
  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam int CW = 8;

  typedef struct packed {
    logic [TW-1:0] dest;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [CW-1:0] ctrl;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  rs_bank_if #(.NUM_ENTRIES(N), .TAG_W(TW), .DATA_W(DW), .CTRL_W(CW)) bus ();

  rs_bank #(.NUM_ENTRIES(N), .TAG_W(TW), .DATA_W(DW), .CTRL_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fire is judged at the negedge, before the posedge that consumes it.
  task automatic sb_check();
    exp_t e;
    if (bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_issue_dest", {59'd0, bus.issue_dest_tag}, 64'hDEAD);
      end else begin
        e = sb_q.pop_front();
        chk("sb_dest", {59'd0, bus.issue_dest_tag}, {59'd0, e.dest});
        chk("sb_opa",  {32'd0, bus.issue_opa},      {32'd0, e.opa});
        chk("sb_opb",  {32'd0, bus.issue_opb},      {32'd0, e.opb});
        chk("sb_ctrl", {56'd0, bus.issue_ctrl},     {56'd0, e.ctrl});
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    sb_check();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_valid = 1'b0;
    bus.cdb_valid      = 1'b0;
    bus.flush          = 1'b0;
  endtask

  task automatic disp(input logic [DW-1:0] a, input logic av, input logic [TW-1:0] at,
                      input logic [DW-1:0] b, input logic bv, input logic [TW-1:0] bt,
                      input logic [TW-1:0] d, input logic [CW-1:0] c);
    bus.dispatch_valid     = 1'b1;
    bus.dispatch_opa       = a;
    bus.dispatch_opa_valid = av;
    bus.dispatch_opa_tag   = at;
    bus.dispatch_opb       = b;
    bus.dispatch_opb_valid = bv;
    bus.dispatch_opb_tag   = bt;
    bus.dispatch_dest_tag  = d;
    bus.dispatch_ctrl      = c;
  endtask

  task automatic cdb(input logic [TW-1:0] t, input logic [DW-1:0] v);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = t;
    bus.cdb_value = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.issue_ready = 1'b1;
    bus.cdb_tag     = '0;
    bus.cdb_value   = '0;

    // Reset held with a dispatch attempt present.
    reset = 1'b0;
    disp(32'h1, 1'b1, 5'd0, 32'h2, 1'b1, 5'd0, 5'd7, 8'h77);
    tick();
    tick();
    chk("rst_free_count", {61'd0, bus.free_count}, 64'd4);
    chk("rst_issue_valid", {63'd0, bus.issue_valid}, 64'd0);
    chk("rst_dispatch_ready", {63'd0, bus.dispatch_ready}, 64'd1);
    chk("rst_full", {63'd0, bus.full}, 64'd0);
    chk("rst_issue_opa", {32'd0, bus.issue_opa}, 64'd0);
    idle();
    reset = 1'b1;
    tick();
    chk("post_rst_free", {61'd0, bus.free_count}, 64'd4);
    chk("post_rst_issue_valid", {63'd0, bus.issue_valid}, 64'd0);

    // Ready dispatch issues next cycle.
    disp(32'h123, 1'b1, 5'd0, 32'h00A, 1'b1, 5'd0, 5'd1, 8'h11);
    sb_q.push_back('{dest: 5'd1, opa: 32'h123, opb: 32'h00A, ctrl: 8'h11});
    tick();
    idle();
    chk("rdy_issue_valid", {63'd0, bus.issue_valid}, 64'd1);
    chk("rdy_issue_opa", {32'd0, bus.issue_opa}, 64'h123);
    chk("rdy_free", {61'd0, bus.free_count}, 64'd3);
    tick();
    chk("rdy_free_after", {61'd0, bus.free_count}, 64'd4);
    chk("rdy_issue_valid_after", {63'd0, bus.issue_valid}, 64'd0);

    // CDB wakeup of operand B.
    disp(32'h123, 1'b1, 5'd0, 32'h0, 1'b0, 5'd3, 5'd4, 8'h22);
    tick();
    idle();
    cdb(5'd3, 32'hFFFFFABC);
    sb_q.push_back('{dest: 5'd4, opa: 32'h123, opb: 32'hFFFFFABC, ctrl: 8'h22});
    chk("wake_cdb_cycle_valid", {63'd0, bus.issue_valid}, 64'd0);
    tick();
    idle();
    chk("wake_issue_valid", {63'd0, bus.issue_valid}, 64'd1);
    chk("wake_issue_opb", {32'd0, bus.issue_opb}, 64'hFFFFFABC);
    tick();
    chk("wake_free_after", {61'd0, bus.free_count}, 64'd4);

    // Same-cycle CDB bypass on dispatch.
    disp(32'hBAD, 1'b0, 5'd2, 32'h7, 1'b1, 5'd0, 5'd5, 8'h33);
    cdb(5'd2, 32'h55);
    sb_q.push_back('{dest: 5'd5, opa: 32'h55, opb: 32'h7, ctrl: 8'h33});
    tick();
    idle();
    chk("byp_issue_valid", {63'd0, bus.issue_valid}, 64'd1);
    chk("byp_issue_opa", {32'd0, bus.issue_opa}, 64'h55);
    tick();

    // Fill, drop a fifth dispatch, then priority of a refilled slot 0.
    bus.issue_ready = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      disp(32'(d * 16), 1'b1, 5'd0, 32'(d), 1'b1, 5'd0, 5'(d), 8'(8'h40 + d));
      tick();
    end
    chk("full_full", {63'd0, bus.full}, 64'd1);
    chk("full_dispatch_ready", {63'd0, bus.dispatch_ready}, 64'd0);
    chk("full_free", {61'd0, bus.free_count}, 64'd0);
    chk("full_issue_dest", {59'd0, bus.issue_dest_tag}, 64'd1);
    disp(32'hEEE, 1'b1, 5'd0, 32'hEEE, 1'b1, 5'd0, 5'd7, 8'hEE);
    tick();
    idle();
    chk("drop_free", {61'd0, bus.free_count}, 64'd0);
    chk("hold_issue_dest", {59'd0, bus.issue_dest_tag}, 64'd1);
    sb_q.push_back('{dest: 5'd1, opa: 32'h10, opb: 32'h1, ctrl: 8'h41});
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("after_pop_free", {61'd0, bus.free_count}, 64'd1);
    chk("after_pop_dest", {59'd0, bus.issue_dest_tag}, 64'd2);
    disp(32'h900, 1'b1, 5'd0, 32'h9, 1'b1, 5'd0, 5'd9, 8'h99);
    tick();
    idle();
    chk("prio_dest", {59'd0, bus.issue_dest_tag}, 64'd9);
    chk("prio_free", {61'd0, bus.free_count}, 64'd0);
    sb_q.push_back('{dest: 5'd9, opa: 32'h900, opb: 32'h9, ctrl: 8'h99});
    for (int d = 2; d <= 4; d++) begin
      sb_q.push_back('{dest: 5'(d), opa: 32'(d * 16), opb: 32'(d), ctrl: 8'(8'h40 + d)});
    end
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("drain_free", {61'd0, bus.free_count}, 64'd4);

    // Simultaneous dispatch and issue leave free_count unchanged.
    disp(32'hA0, 1'b1, 5'd0, 32'hA1, 1'b1, 5'd0, 5'd10, 8'hAA);
    sb_q.push_back('{dest: 5'd10, opa: 32'hA0, opb: 32'hA1, ctrl: 8'hAA});
    tick();
    chk("sim_free_before", {61'd0, bus.free_count}, 64'd3);
    disp(32'hB0, 1'b1, 5'd0, 32'hB1, 1'b1, 5'd0, 5'd11, 8'hBB);
    sb_q.push_back('{dest: 5'd11, opa: 32'hB0, opb: 32'hB1, ctrl: 8'hBB});
    tick();
    idle();
    chk("sim_free_net", {61'd0, bus.free_count}, 64'd3);
    tick();
    chk("sim_free_after", {61'd0, bus.free_count}, 64'd4);

    // Flush with pending entries, one ready entry and a matching CDB.
    bus.issue_ready = 1'b0;
    for (int d = 12; d <= 14; d++) begin
      disp(32'h0, 1'b0, 5'd6, 32'(d), 1'b1, 5'd0, 5'(d), 8'(d));
      tick();
    end
    disp(32'h16, 1'b1, 5'd0, 32'h16, 1'b1, 5'd0, 5'd16, 8'h16);
    tick();
    idle();
    chk("pre_flush_valid", {63'd0, bus.issue_valid}, 64'd1);
    chk("pre_flush_dest", {59'd0, bus.issue_dest_tag}, 64'd16);
    bus.issue_ready = 1'b1;
    bus.flush = 1'b1;
    cdb(5'd6, 32'h99);
    disp(32'h1, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 5'd15, 8'h15);
    #1;
    chk("flush_issue_valid", {63'd0, bus.issue_valid}, 64'd0);
    chk("flush_issue_dest", {59'd0, bus.issue_dest_tag}, 64'd0);
    chk("flush_dispatch_ready", {63'd0, bus.dispatch_ready}, 64'd0);
    tick();
    idle();
    chk("post_flush_free", {61'd0, bus.free_count}, 64'd4);
    chk("post_flush_valid", {63'd0, bus.issue_valid}, 64'd0);
    cdb(5'd6, 32'h99);
    tick();
    idle();
    tick();
    chk("post_flush_wake_valid", {63'd0, bus.issue_valid}, 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
- Parametrised, multi-entry reservation station that generalises the single-entry RS used by the dispatch stage.
- Accepts one dispatched instruction per cycle with renamed operands (value or ROB tag), snoops the CDB to wake pending operands, and issues one ready instruction per cycle to execute through a valid/ready handshake.
- Sits between stage_id dispatch logic and the functional unit.
- Adds same-cycle CDB bypass on dispatch, fixed-priority issue select, occupancy reporting and flush.

Parameters:
NUM_ENTRIES, 4, number of RS entries (>=2)
TAG_W, 5, ROB tag width
DATA_W, 32, operand/CDB value width
CTRL_W, 8, opaque control payload carried with the instruction (ALU select, funct, has_dest, etc.)

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-low reset (0 = reset)
dispatch_valid  in  1  dispatch request
dispatch_ready  out  1  at least one free entry
dispatch_opa  in  DATA_W  operand A value
dispatch_opa_valid  in  1  operand A value is final
dispatch_opa_tag  in  TAG_W  producer tag when not valid
dispatch_opb  in  DATA_W  operand B value
dispatch_opb_valid  in  1  operand B value is final
dispatch_opb_tag  in  TAG_W  producer tag when not valid
dispatch_dest_tag  in  TAG_W  ROB tag of this instruction
dispatch_ctrl  in  CTRL_W  control payload
cdb_valid  in  1  CDB broadcast
cdb_tag  in  TAG_W  broadcast tag
cdb_value  in  DATA_W  broadcast value
issue_valid  out  1  a ready entry is presented
issue_ready  in  1  FU accepts
issue_opa  out  DATA_W  selected operand A
issue_opb  out  DATA_W  selected operand B
issue_dest_tag  out  TAG_W  selected dest tag
issue_ctrl  out  CTRL_W  selected payload
flush  in  1  squash all entries
free_count  out  $clog2(NUM_ENTRIES+1)  free entries
full  out  1  free_count == 0

Behaviour:
- Entry state: busy, opa/opb value, opa/opb ready, opa/opb tag, dest_tag, ctrl.
- Reset (reset==0 at posedge): all entries not busy. Outputs: issue_valid=0; issue_* data=0; dispatch_ready=1; free_count=NUM_ENTRIES; full=0. Reset takes priority over flush, dispatch, CDB and issue.
- Dispatch fires on dispatch_valid && dispatch_ready.
  - Writes the lowest-index free entry at the posedge.
  - dispatch_ready = !full, computed from registered state only. A slot freed by a same-cycle issue is not usable until the next cycle.
- Operand capture on dispatch: if operand valid=0, cdb_valid=1 and cdb_tag equals the operand tag, store cdb_value and mark ready (bypass). Otherwise store as given. The tag field is ignored when valid=1.
- CDB wakeup: each busy entry with a non-ready operand whose tag == cdb_tag (cdb_valid=1) captures cdb_value and sets ready at the posedge. Both operands of one entry may wake on the same broadcast. Multiple entries may wake simultaneously.
- Ready entry: busy && opa ready && opb ready.
- Issue select: lowest-index ready entry.
  - issue_valid and issue_* are combinational from registered state only; there is no CDB-to-issue combinational path.
  - Wakeup-to-issue latency: 1 cycle after the CDB edge. Dispatch-to-issue latency (operands ready or bypassed): 1 cycle.
  - issue_* = 0 when issue_valid=0.
- Issue fire (issue_valid && issue_ready): the selected entry is cleared at the posedge. While issue_ready=0, issue_* hold the same entry, unless a lower-index entry becomes ready, in which case the selection switches to it.
- Simultaneous dispatch and issue: both take effect; free_count is unchanged net.
- flush=1:
  - issue_valid forced 0.
  - dispatch_ready forced 0.
  - At the posedge all entries are cleared; dispatch and CDB in that cycle are ignored.
- free_count/full are registered-state derived and update the cycle after a dispatch, issue or flush.
- CDB tags matching no entry are ignored. Dest tags are not checked for uniqueness.

Test Plan:
- Reset: hold reset=0 for 2 cycles with dispatch_valid=1 -> free_count=4, issue_valid=0, dispatch_ready=1; after release, no entry is busy.
- Ready dispatch: opa=0x123 valid, opb=0x00A valid, dest=1, issue_ready=1 -> next cycle issue_valid=1, issue_opa=0x123, issue_opb=0x00A, dest=1; cycle after, free_count=4.
- Wakeup: dispatch opa=0x123 valid, opb tag=3 not ready, dest=4; next cycle cdb tag=3 value=0xFFFFFABC -> issue_valid=0 on the CDB cycle, =1 the following cycle with issue_opb=0xFFFFFABC.
- Bypass: dispatch opa tag=2 not ready while cdb_valid=1, tag=2, value=0x55 -> next cycle issue_valid=1, issue_opa=0x55.
- Full/priority: issue_ready=0, dispatch 4 ready instrs (dest 1..4) -> full=1, dispatch_ready=0, 5th dispatch dropped, issue_dest_tag=1. Clear entry 0 via issue, then dispatch dest=9 -> lands in index 0 and issues before dest 2.
- Flush: 3 entries pending tags, flush=1 with cdb tag matching -> issue_valid=0 that cycle; next cycle free_count=4, nothing issues.
